intt_stream_ctrl: RTL

//  Sequencer for the dual-lane pipelined INTT. Streams one N-coefficient polynomial as N/2 lane

---
 rtl/intt_stream_ctrl_if.sv | 55 +++++
 rtl/intt_stream_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/intt_stream_ctrl_if.sv
// -----------------------------------------------------------------------------
// intt_stream_ctrl_if
//   Bundles every signal between the INTT stream sequencer and its
//   surroundings: the scheduler handshake, the source RAM read port, the dual
//   lane INTT pipeline ports and the destination RAM write port.
//
//   master : the sequencer side (drives busy/done/err, RAM controls, intt_in*)
//   slave  : the environment side (scheduler, RAMs and the INTT pipeline)
//
//   Signals
//     start, busy, done, err          scheduler handshake / sticky error
//     src_re, src_addr, src_rdata[2]  source RAM, data valid 1 cycle after src_re
//     intt_in_en, intt_in[2]          pair stream into the INTT
//     intt_out_en, intt_out[2]        pair stream out of the INTT
//     intt_fifo1_addr                 shared fifo1 rotation address
//     dst_we, dst_addr, dst_wdata[2]  destination RAM write port
// -----------------------------------------------------------------------------
interface intt_stream_ctrl_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int NTT_STAGE_CNT = 7,
  parameter int FA_W          = 3
);

  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     err;

  logic                     src_re;
  logic [NTT_STAGE_CNT-1:0] src_addr;
  logic [DATA_WIDTH-1:0]    src_rdata [2];

  logic                     intt_in_en;
  logic [DATA_WIDTH-1:0]    intt_in [2];
  logic                     intt_out_en;
  logic [DATA_WIDTH-1:0]    intt_out [2];
  logic [FA_W-1:0]          intt_fifo1_addr;

  logic                     dst_we;
  logic [NTT_STAGE_CNT-1:0] dst_addr;
  logic [DATA_WIDTH-1:0]    dst_wdata [2];

  modport master (
    input  start, src_rdata, intt_out_en, intt_out,
    output busy, done, err, src_re, src_addr, intt_in_en, intt_in,
           intt_fifo1_addr, dst_we, dst_addr, dst_wdata
  );

  modport slave (
    output start, src_rdata, intt_out_en, intt_out,
    input  busy, done, err, src_re, src_addr, intt_in_en, intt_in,
           intt_fifo1_addr, dst_we, dst_addr, dst_wdata
  );

endinterface

// File: rtl/intt_stream_ctrl.sv
// -----------------------------------------------------------------------------
// intt_stream_ctrl
//   Sequencer for the dual-lane pipelined INTT. On an accepted start it reads
//   one polynomial (PAIR_CNT lane pairs) from the source RAM and streams it
//   into the INTT as one gap-free intt_in_en burst, keeps the shared
//   fifo1_addr rotation running, and writes the INTT output burst to the
//   destination RAM. Protocol errors and output timeouts set a sticky err.
//
//   Ports
//     clk   in  clock, all logic on the rising edge
//     rst   in  synchronous active-high reset
//     bus   intt_stream_ctrl_if.master (handshake, RAM ports, INTT ports)
//
//   Coefficients pass through unchanged; no arithmetic on data.
// -----------------------------------------------------------------------------
module intt_stream_ctrl #(
  parameter int DATA_WIDTH    = 16,
  parameter int NTT_STAGE_CNT = 7,
  parameter int MUL_STAGE_CNT = 6,
  parameter int FA_W          = $clog2(MUL_STAGE_CNT - 1),
  parameter int LAT_MAX       = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  intt_stream_ctrl_if.master        bus
);

  localparam int PAIR_CNT = 2 ** NTT_STAGE_CNT;
  // One extra bit so "all PAIR_CNT outputs written" is distinguishable from 0.
  localparam int CNT_W    = NTT_STAGE_CNT + 1;
  localparam int WD_W     = $clog2(LAT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;

  logic [NTT_STAGE_CNT-1:0] rd_cnt_q;
  logic [CNT_W-1:0]         wr_cnt_q;
  logic [WD_W-1:0]          wd_q;
  logic [FA_W-1:0]          fa_q;
  logic                     rd_vld_q;    // src_rdata holds a requested pair
  logic                     in_seen_q;   // at least one pair entered the INTT
  logic                     err_q;

  logic                     in_en_q;
  logic [DATA_WIDTH-1:0]    in_data_q [2];
  logic                     we_q;
  logic [NTT_STAGE_CNT-1:0] waddr_q;
  logic [DATA_WIDTH-1:0]    wdata_q [2];

  logic                     start_acc;
  logic                     out_acc;
  logic                     err_set;
  logic                     wr_full;
  logic                     wr_partial;

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d    = state_q;
    start_acc  = 1'b0;
    out_acc    = 1'b0;
    err_set    = 1'b0;
    wr_full    = (wr_cnt_q == CNT_W'(PAIR_CNT));
    wr_partial = (wr_cnt_q != '0) && !wr_full;

    unique case (state_q)
      S_IDLE: begin
        // Output beats with no polynomial in flight are a protocol error.
        if (bus.intt_out_en) err_set = 1'b1;
        if (bus.start) begin
          start_acc = 1'b1;
          state_d   = S_FEED;
        end
      end

      S_FEED: begin
        if (bus.intt_out_en) begin
          if (in_seen_q && !wr_full) out_acc = 1'b1;
          else                       err_set = 1'b1;
        end
        if (!bus.intt_out_en && wr_partial) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end else if (rd_cnt_q == NTT_STAGE_CNT'(PAIR_CNT - 1)) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (bus.intt_out_en) begin
          // Beats beyond PAIR_CNT are flagged and dropped.
          if (wr_full) err_set = 1'b1;
          else         out_acc = 1'b1;
        end else if (wr_full) begin
          state_d = S_DONE;
        end else if (wr_partial) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end else if (wd_q == WD_W'(LAT_MAX - 1)) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_DONE: begin
        if (bus.intt_out_en) err_set = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counters and registered data paths
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (rst) begin
      state_q      <= S_IDLE;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      wd_q         <= '0;
      fa_q         <= '0;
      rd_vld_q     <= 1'b0;
      in_seen_q    <= 1'b0;
      err_q        <= 1'b0;
      in_en_q      <= 1'b0;
      in_data_q[0] <= '0;
      in_data_q[1] <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q[0]   <= '0;
      wdata_q[1]   <= '0;
    end else begin
      state_q <= state_d;

      // The rotation runs regardless of state so the INTT's shared fifo
      // never sees a discontinuity across polynomials.
      if (fa_q == FA_W'(MUL_STAGE_CNT - 2)) fa_q <= '0;
      else                                  fa_q <= fa_q + FA_W'(1);

      // Read data arrives one cycle after src_re; the enable is delayed the
      // same amount so intt_in_en and intt_in stay aligned and gap-free.
      rd_vld_q <= (state_q == S_FEED);
      in_en_q  <= rd_vld_q;
      if (rd_vld_q) begin
        in_data_q[0] <= bus.src_rdata[0];
        in_data_q[1] <= bus.src_rdata[1];
      end
      if (in_en_q) in_seen_q <= 1'b1;

      if (start_acc) begin
        rd_cnt_q  <= '0;
        wr_cnt_q  <= '0;
        in_seen_q <= 1'b0;
      end else begin
        if (state_q == S_FEED) rd_cnt_q <= rd_cnt_q + NTT_STAGE_CNT'(1);
        if (out_acc)           wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      end

      // Watchdog only runs until the first output beat arrives.
      if (state_q == S_FEED && state_d == S_DRAIN) wd_q <= '0;
      else if (state_q == S_DRAIN && wr_cnt_q == '0) wd_q <= wd_q + WD_W'(1);

      we_q <= out_acc;
      if (out_acc) begin
        waddr_q    <= wr_cnt_q[NTT_STAGE_CNT-1:0];
        wdata_q[0] <= bus.intt_out[0];
        wdata_q[1] <= bus.intt_out[1];
      end

      // A new error in the same cycle as an accepted start still sticks.
      if (err_set)        err_q <= 1'b1;
      else if (start_acc) err_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.busy            = (state_q == S_FEED) || (state_q == S_DRAIN);
  assign bus.done            = (state_q == S_DONE);
  assign bus.err             = err_q;
  assign bus.src_re          = (state_q == S_FEED);
  assign bus.src_addr        = rd_cnt_q;
  assign bus.intt_in_en      = in_en_q;
  assign bus.intt_in[0]      = in_data_q[0];
  assign bus.intt_in[1]      = in_data_q[1];
  assign bus.intt_fifo1_addr = fa_q;
  assign bus.dst_we          = we_q;
  assign bus.dst_addr        = waddr_q;
  assign bus.dst_wdata[0]    = wdata_q[0];
  assign bus.dst_wdata[1]    = wdata_q[1];

endmodule
